// File: rtl/commit_reorder_buffer.sv
// In-order retirement buffer behind the 4-wide rename stage.
// Accepts up to 4 instructions per cycle, completes them from 2 writeback ports, and retires 1 per cycle.
module commit_reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int PHY_W  = 6,
  parameter int ARCH_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Alloc_En,
  input  logic              Inst1_Valid,
  input  logic              Inst1_RegW,
  input  logic [ARCH_W-1:0] Inst1_Rdst,
  input  logic [PHY_W-1:0]  Inst1_Phydst,
  input  logic              Inst2_Valid,
  input  logic              Inst2_RegW,
  input  logic [ARCH_W-1:0] Inst2_Rdst,
  input  logic [PHY_W-1:0]  Inst2_Phydst,
  input  logic              Inst3_Valid,
  input  logic              Inst3_RegW,
  input  logic [ARCH_W-1:0] Inst3_Rdst,
  input  logic [PHY_W-1:0]  Inst3_Phydst,
  input  logic              Inst4_Valid,
  input  logic              Inst4_RegW,
  input  logic [ARCH_W-1:0] Inst4_Rdst,
  input  logic [PHY_W-1:0]  Inst4_Phydst,
  output logic [IDX_W-1:0]  Alloc1_Idx,
  output logic [IDX_W-1:0]  Alloc2_Idx,
  output logic [IDX_W-1:0]  Alloc3_Idx,
  output logic [IDX_W-1:0]  Alloc4_Idx,
  output logic              ROB_Stall,
  input  logic              WB1_Valid,
  input  logic [IDX_W-1:0]  WB1_Idx,
  input  logic              WB1_Mispredict,
  input  logic              WB2_Valid,
  input  logic [IDX_W-1:0]  WB2_Idx,
  output logic              Commit,
  output logic [PHY_W-1:0]  Commit_Phy,
  output logic [ARCH_W-1:0] Commit_Rdst,
  output logic              Retire,
  output logic              Branch_flush,
  output logic [IDX_W:0]    Count
);

  typedef struct packed {
    logic              regw;
    logic [ARCH_W-1:0] rdst;
    logic [PHY_W-1:0]  phy;
  } payload_t;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  logic [DEPTH-1:0] mis;
  payload_t         pay [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  logic [3:0]       lv;
  payload_t         lp [4];
  logic [IDX_W-1:0] li [4];
  logic [IDX_W-1:0] off;
  logic [2:0]       n;
  logic [IDX_W+1:0] need;
  logic             accept;
  logic             retire;
  logic             flush;
  logic             wb1_ok;
  logic             wb2_ok;

  // Valid lanes are packed onto consecutive entries starting at tail.
  always_comb begin
    lv = {Inst4_Valid, Inst3_Valid, Inst2_Valid, Inst1_Valid};
    lp[0] = payload_t'{Inst1_RegW, Inst1_Rdst, Inst1_Phydst};
    lp[1] = payload_t'{Inst2_RegW, Inst2_Rdst, Inst2_Phydst};
    lp[2] = payload_t'{Inst3_RegW, Inst3_Rdst, Inst3_Phydst};
    lp[3] = payload_t'{Inst4_RegW, Inst4_Rdst, Inst4_Phydst};
    off = '0;
    n = '0;
    for (int k = 0; k < 4; k++) begin
      li[k] = tail + off;
      if (lv[k]) begin
        off = off + 1'b1;
        n = n + 1'b1;
      end
    end
  end

  assign Alloc1_Idx = li[0];
  assign Alloc2_Idx = li[1];
  assign Alloc3_Idx = li[2];
  assign Alloc4_Idx = li[3];

  assign need = (IDX_W+2)'(Count) + (IDX_W+2)'(n);
  assign ROB_Stall = Branch_flush | (need > (IDX_W+2)'(DEPTH));
  assign accept = Alloc_En & ~ROB_Stall;
  assign retire = valid[head] & done[head] & (Count != '0);
  assign flush = retire & mis[head];
  assign wb1_ok = WB1_Valid & valid[WB1_Idx] & ~Branch_flush;
  assign wb2_ok = WB2_Valid & valid[WB2_Idx] & ~Branch_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      done <= '0;
      mis <= '0;
      for (int i = 0; i < DEPTH; i++) pay[i] <= '0;
      head <= '0;
      tail <= '0;
      Count <= '0;
      Commit <= 1'b0;
      Commit_Phy <= '0;
      Commit_Rdst <= '0;
      Retire <= 1'b0;
      Branch_flush <= 1'b0;
    end else begin
      Retire <= retire;
      Commit <= retire & pay[head].regw & (pay[head].rdst != '0);
      Branch_flush <= flush;
      if (retire) begin
        Commit_Phy <= pay[head].phy;
        Commit_Rdst <= pay[head].rdst;
      end
      // A mispredicted head squashes everything younger, same-cycle traffic included.
      if (flush) begin
        valid <= '0;
        head <= head + 1'b1;
        tail <= head + 1'b1;
        Count <= '0;
      end else begin
        if (wb1_ok) begin
          done[WB1_Idx] <= 1'b1;
          mis[WB1_Idx] <= WB1_Mispredict;
        end
        if (wb2_ok) done[WB2_Idx] <= 1'b1;
        if (accept) begin
          for (int k = 0; k < 4; k++) begin
            if (lv[k]) begin
              valid[li[k]] <= 1'b1;
              done[li[k]] <= 1'b0;
              mis[li[k]] <= 1'b0;
              pay[li[k]] <= lp[k];
            end
          end
          tail <= tail + IDX_W'(n);
        end
        if (retire) begin
          valid[head] <= 1'b0;
          head <= head + 1'b1;
        end
        Count <= Count + (accept ? (IDX_W+1)'(n) : '0) - (IDX_W+1)'(retire);
      end
    end
  end

endmodule

// File: tb/tb_commit_reorder_buffer.sv
// Directed bench for commit_reorder_buffer.
// Walks allocation, out-of-order completion, full, flush and reset cases.
module tb_commit_reorder_buffer;

  logic       clk;
  logic       rst;
  logic       alloc_en;
  logic [3:0] v;
  logic [3:0] w;
  logic [4:0] rd [4];
  logic [5:0] ph [4];
  logic [3:0] idx1, idx2, idx3, idx4;
  logic       stall;
  logic       wb1_v, wb1_m, wb2_v;
  logic [3:0] wb1_i, wb2_i;
  logic       commit, retire, bflush;
  logic [5:0] cphy;
  logic [4:0] crd;
  logic [4:0] count;

  int vectors = 0;
  int miscompares = 0;

  commit_reorder_buffer dut (
    .clk(clk), .rst(rst), .Alloc_En(alloc_en),
    .Inst1_Valid(v[0]), .Inst1_RegW(w[0]), .Inst1_Rdst(rd[0]), .Inst1_Phydst(ph[0]),
    .Inst2_Valid(v[1]), .Inst2_RegW(w[1]), .Inst2_Rdst(rd[1]), .Inst2_Phydst(ph[1]),
    .Inst3_Valid(v[2]), .Inst3_RegW(w[2]), .Inst3_Rdst(rd[2]), .Inst3_Phydst(ph[2]),
    .Inst4_Valid(v[3]), .Inst4_RegW(w[3]), .Inst4_Rdst(rd[3]), .Inst4_Phydst(ph[3]),
    .Alloc1_Idx(idx1), .Alloc2_Idx(idx2), .Alloc3_Idx(idx3), .Alloc4_Idx(idx4),
    .ROB_Stall(stall),
    .WB1_Valid(wb1_v), .WB1_Idx(wb1_i), .WB1_Mispredict(wb1_m),
    .WB2_Valid(wb2_v), .WB2_Idx(wb2_i),
    .Commit(commit), .Commit_Phy(cphy), .Commit_Rdst(crd),
    .Retire(retire), .Branch_flush(bflush), .Count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grp(input logic [3:0] vv, input int base);
    v = vv;
    w = 4'hf;
    for (int k = 0; k < 4; k++) begin
      rd[k] = 5'(k + 1);
      ph[k] = 6'(base + k);
    end
  endtask

  initial begin
    rst = 1'b0;
    alloc_en = 1'b0;
    grp(4'hf, 10);
    wb1_v = 1'b0; wb1_m = 1'b0; wb1_i = '0;
    wb2_v = 1'b0; wb2_i = '0;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_commit", 32'(commit), 0);
    chk("rst_flush", 32'(bflush), 0);
    chk("rst_stall_n4", 32'(stall), 0);
    #1;
    rst = 1'b1;
    alloc_en = 1'b1;
    #1;
    chk("alloc1_idx", 32'(idx1), 0);
    chk("alloc2_idx", 32'(idx2), 1);
    chk("alloc3_idx", 32'(idx3), 2);
    chk("alloc4_idx", 32'(idx4), 3);
    step();
    alloc_en = 1'b0;
    v = '0;
    chk("count_after_alloc4", 32'(count), 4);

    // Out-of-order completion 2,0,1,3
    wb2_v = 1'b1; wb2_i = 4'd2;
    step();
    wb2_v = 1'b0;
    wb1_v = 1'b1; wb1_i = 4'd0;
    step();
    chk("ooo_no_commit_yet", 32'(commit), 0);
    wb1_v = 1'b0;
    wb2_v = 1'b1; wb2_i = 4'd1;
    step();
    chk("ooo_c0", 32'(commit), 1);
    chk("ooo_c0_phy", 32'(cphy), 10);
    chk("ooo_c0_rd", 32'(crd), 1);
    chk("ooo_c0_count", 32'(count), 3);
    wb2_v = 1'b0;
    wb1_v = 1'b1; wb1_i = 4'd3;
    step();
    wb1_v = 1'b0;
    chk("ooo_c1_phy", 32'(cphy), 11);
    chk("ooo_c1_rd", 32'(crd), 2);
    step();
    chk("ooo_c2_phy", 32'(cphy), 12);
    step();
    chk("ooo_c3", 32'(commit), 1);
    chk("ooo_c3_phy", 32'(cphy), 13);
    chk("ooo_c3_count", 32'(count), 0);
    step();
    chk("idle_commit", 32'(commit), 0);
    chk("idle_retire", 32'(retire), 0);
    chk("idle_phy_hold", 32'(cphy), 13);

    // Non-RegW and Rdst=0, lanes 1 and 3 only
    v = 4'b0101;
    w = 4'b0100;
    rd[0] = 5'd5; ph[0] = 6'd20;
    rd[2] = 5'd0; ph[2] = 6'd21;
    alloc_en = 1'b1;
    #1;
    chk("compact_idx1", 32'(idx1), 4);
    chk("compact_idx3", 32'(idx3), 5);
    step();
    alloc_en = 1'b0;
    v = '0;
    chk("compact_count", 32'(count), 2);
    wb1_v = 1'b1; wb1_i = 4'd4;
    wb2_v = 1'b1; wb2_i = 4'd5;
    step();
    wb1_v = 1'b0; wb2_v = 1'b0;
    step();
    chk("noregw_retire", 32'(retire), 1);
    chk("noregw_commit", 32'(commit), 0);
    step();
    chk("rd0_retire", 32'(retire), 1);
    chk("rd0_commit", 32'(commit), 0);
    chk("rd0_count", 32'(count), 0);

    // Fill to 16 starting at entry 6
    grp(4'hf, 30);
    alloc_en = 1'b1;
    for (int g = 0; g < 4; g++) step();
    chk("full_count", 32'(count), 16);
    grp(4'b0001, 30);
    #1;
    chk("full_stall", 32'(stall), 1);
    wb1_v = 1'b1; wb1_i = 4'd6;
    step();
    wb1_v = 1'b0;
    chk("full_count_hold", 32'(count), 16);
    chk("full_stall_again", 32'(stall), 1);
    step();
    chk("full_retire", 32'(retire), 1);
    chk("full_retire_phy", 32'(cphy), 30);
    chk("full_count_15", 32'(count), 15);
    chk("full_unstall", 32'(stall), 0);
    chk("full_wrap_idx", 32'(idx1), 6);
    step();
    alloc_en = 1'b0;
    v = '0;
    chk("full_refill", 32'(count), 16);

    #3;
    rst = 1'b0;
    #1;
    chk("rst2_count", 32'(count), 0);
    step();
    rst = 1'b1;

    // Mispredict at entry 2
    grp(4'hf, 40);
    alloc_en = 1'b1;
    step();
    grp(4'b0011, 44);
    step();
    alloc_en = 1'b0;
    v = '0;
    chk("mp_count6", 32'(count), 6);
    wb1_v = 1'b1; wb1_i = 4'd0;
    wb2_v = 1'b1; wb2_i = 4'd1;
    step();
    chk("mp_no_retire", 32'(retire), 0);
    wb1_i = 4'd2; wb1_m = 1'b1;
    wb2_i = 4'd3;
    step();
    wb1_v = 1'b0; wb1_m = 1'b0; wb2_v = 1'b0;
    chk("mp_c0_phy", 32'(cphy), 40);
    step();
    chk("mp_c1_phy", 32'(cphy), 41);
    chk("mp_c1_noflush", 32'(bflush), 0);
    chk("mp_c1_count", 32'(count), 4);
    grp(4'b0001, 60);
    alloc_en = 1'b1;
    #1;
    chk("mp_pre_stall", 32'(stall), 0);
    step();
    chk("mp_commit", 32'(commit), 1);
    chk("mp_phy", 32'(cphy), 42);
    chk("mp_rd", 32'(crd), 3);
    chk("mp_flush", 32'(bflush), 1);
    chk("mp_count0", 32'(count), 0);
    chk("mp_flush_stall", 32'(stall), 1);
    alloc_en = 1'b0;
    step();
    chk("mp_flush_pulse", 32'(bflush), 0);
    chk("mp_post_retire", 32'(retire), 0);
    chk("mp_post_count", 32'(count), 0);
    grp(4'b0001, 50);
    alloc_en = 1'b1;
    #1;
    chk("mp_next_idx", 32'(idx1), 3);
    step();
    chk("mp_next_count", 32'(count), 1);

    // Reset mid-operation with Count=9 and a writeback pending
    grp(4'hf, 54);
    step();
    grp(4'hf, 58);
    step();
    grp(4'b0001, 62);
    step();
    alloc_en = 1'b0;
    v = '0;
    chk("mid_count10", 32'(count), 10);
    wb1_v = 1'b1; wb1_i = 4'd3;
    step();
    wb1_v = 1'b0;
    step();
    chk("mid_commit", 32'(commit), 1);
    chk("mid_commit_phy", 32'(cphy), 50);
    chk("mid_count9", 32'(count), 9);
    wb1_v = 1'b1; wb1_i = 4'd4;
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_commit", 32'(commit), 0);
    chk("mid_rst_phy", 32'(cphy), 0);
    chk("mid_rst_rd", 32'(crd), 0);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_retire", 32'(retire), 0);
    chk("mid_rst_flush", 32'(bflush), 0);
    step();
    step();
    wb1_v = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("post_rst_commit", 32'(commit), 0);
    chk("post_rst_retire", 32'(retire), 0);
    chk("post_rst_count", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
